// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32 control FSM: fetch/decode/exec/mem/writeback sequencing with a retire counter.
// Define MC_CTRL_HALT_EN to decode opcode 1110011 into an absorbing HALT state instead of TRAP.
module mc_ctrl_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Inst,
    input  logic        BrTaken,
    input  logic        Mem_Ready,
    output logic        PC_Write,
    output logic [1:0]  PCSrc,
    output logic        IR_Write,
    output logic        IorD,
    output logic        Mem_Read,
    output logic        Mem_Write,
    output logic [1:0]  ALUSrcA,
    output logic        ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  ResultSel,
    output logic        Reg_Write,
    output logic [2:0]  State,
    output logic        Illegal,
    output logic        Halted,
    output logic [31:0] Inst_Count
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5,
        StHalt   = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        ClsNone, ClsR, ClsI, ClsLoad, ClsStore, ClsBranch, ClsJal, ClsJalr, ClsLui, ClsAuipc
    } cls_e;

    state_e      state_q, state_d;
    cls_e        cls_q, cls_d;
    logic [31:0] cnt_q, cnt_d;
    cls_e        dec_cls;

    // Only the opcode field steers control; the rest belongs to the datapath.
    logic unused_inst;
    assign unused_inst = ^Inst[31:7];

    always_comb begin
        dec_cls = ClsNone;
        case (Inst[6:0])
            7'b0110011: dec_cls = ClsR;
            7'b0010011: dec_cls = ClsI;
            7'b0000011: dec_cls = ClsLoad;
            7'b0100011: dec_cls = ClsStore;
            7'b1100011: dec_cls = ClsBranch;
            7'b1101111: dec_cls = ClsJal;
            7'b1100111: dec_cls = ClsJalr;
            7'b0110111: dec_cls = ClsLui;
            7'b0010111: dec_cls = ClsAuipc;
            default:    dec_cls = ClsNone;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cnt_d   = cnt_q;
        case (state_q)
            StFetch: begin
                if (Mem_Ready) state_d = StDecode;
            end
            StDecode: begin
                cls_d = dec_cls;
`ifdef MC_CTRL_HALT_EN
                if (Inst[6:0] == 7'b1110011) state_d = StHalt;
                else if (dec_cls == ClsNone) state_d = StTrap;
                else                         state_d = StExec;
`else
                if (dec_cls == ClsNone) state_d = StTrap;
                else                    state_d = StExec;
`endif
            end
            StExec: begin
                case (cls_q)
                    ClsLoad, ClsStore: state_d = StMem;
                    ClsBranch: begin
                        state_d = StFetch;
                        cnt_d   = cnt_q + 32'd1;
                    end
                    default: state_d = StWb;
                endcase
            end
            StMem: begin
                if (Mem_Ready) begin
                    if (cls_q == ClsLoad) begin
                        state_d = StWb;
                    end else begin
                        state_d = StFetch;
                        cnt_d   = cnt_q + 32'd1;
                    end
                end
            end
            StWb: begin
                state_d = StFetch;
                cnt_d   = cnt_q + 32'd1;
            end
            StTrap:  state_d = StTrap;
            StHalt:  state_d = StHalt;
            default: state_d = StTrap;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StFetch;
            cls_q   <= ClsNone;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
        end
    end

    // Controls are a function of state and latched class; the FETCH/MEM handshake and
    // branch redirect also look at the current-cycle strobes. Held low while in reset.
    always_comb begin
        PC_Write  = 1'b0;
        PCSrc     = 2'd0;
        IR_Write  = 1'b0;
        IorD      = 1'b0;
        Mem_Read  = 1'b0;
        Mem_Write = 1'b0;
        ALUSrcA   = 2'd0;
        ALUSrcB   = 1'b0;
        ALUOp     = 2'd0;
        ResultSel = 2'd0;
        Reg_Write = 1'b0;
        if (rst) begin
            case (state_q)
                StFetch: begin
                    Mem_Read = 1'b1;
                    if (Mem_Ready) begin
                        IR_Write = 1'b1;
                        PC_Write = 1'b1;
                    end
                end
                StExec: begin
                    case (cls_q)
                        ClsR:              ALUOp = 2'd2;
                        ClsI: begin
                            ALUSrcB = 1'b1;
                            ALUOp   = 2'd2;
                        end
                        ClsLoad, ClsStore: ALUSrcB = 1'b1;
                        ClsLui: begin
                            ALUSrcA = 2'd2;
                            ALUSrcB = 1'b1;
                        end
                        ClsAuipc: begin
                            ALUSrcA = 2'd1;
                            ALUSrcB = 1'b1;
                        end
                        ClsBranch: begin
                            ALUOp = 2'd1;
                            if (BrTaken) begin
                                PC_Write = 1'b1;
                                PCSrc    = 2'd1;
                            end
                        end
                        ClsJal: begin
                            PC_Write = 1'b1;
                            PCSrc    = 2'd1;
                        end
                        ClsJalr: begin
                            ALUSrcB  = 1'b1;
                            PC_Write = 1'b1;
                            PCSrc    = 2'd2;
                        end
                        default: ;
                    endcase
                end
                StMem: begin
                    IorD      = 1'b1;
                    Mem_Read  = (cls_q == ClsLoad);
                    Mem_Write = (cls_q == ClsStore);
                end
                StWb: begin
                    Reg_Write = 1'b1;
                    if (cls_q == ClsLoad)                           ResultSel = 2'd1;
                    else if (cls_q == ClsJal || cls_q == ClsJalr)   ResultSel = 2'd2;
                    else                                            ResultSel = 2'd0;
                end
                default: ;
            endcase
        end
    end

    assign State      = state_q;
    assign Illegal    = (state_q == StTrap);
    assign Inst_Count = cnt_q;
`ifdef MC_CTRL_HALT_EN
    assign Halted     = (state_q == StHalt);
`else
    assign Halted     = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed scenarios plus random instruction streams checked cycle by
// cycle against a per-instruction expected trace built from the opcode class.
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        br_taken;
    logic        mem_ready;
    logic        pc_write, ir_write, iord, mem_read, mem_write, alusrcb, reg_write;
    logic        illegal, halted;
    logic [1:0]  pcsrc, alusrca, aluop, resultsel;
    logic [2:0]  state;
    logic [31:0] inst_count;

    mc_ctrl_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .Inst       (inst),
        .BrTaken    (br_taken),
        .Mem_Ready  (mem_ready),
        .PC_Write   (pc_write),
        .PCSrc      (pcsrc),
        .IR_Write   (ir_write),
        .IorD       (iord),
        .Mem_Read   (mem_read),
        .Mem_Write  (mem_write),
        .ALUSrcA    (alusrca),
        .ALUSrcB    (alusrcb),
        .ALUOp      (aluop),
        .ResultSel  (resultsel),
        .Reg_Write  (reg_write),
        .State      (state),
        .Illegal    (illegal),
        .Halted     (halted),
        .Inst_Count (inst_count)
    );

    always #5 clk = ~clk;

    localparam int CR = 0, CI = 1, CLD = 2, CST = 3, CBR = 4, CJAL = 5, CJALR = 6;
    localparam int CLUI = 7, CAUI = 8, CHALT = 9;
    localparam int KRetire = 0, KTrap = 1, KHalt = 2, KReset = 3;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_count;

    logic       e_pcw, e_irw, e_iord, e_mr, e_mw, e_asb, e_rw, e_ill, e_hlt;
    logic [1:0] e_pcsrc, e_asa, e_aop, e_rsel;
    logic [2:0] e_state;

    function automatic int cls_of(input logic [6:0] op);
        case (op)
            7'b0110011: return CR;
            7'b0010011: return CI;
            7'b0000011: return CLD;
            7'b0100011: return CST;
            7'b1100011: return CBR;
            7'b1101111: return CJAL;
            7'b1100111: return CJALR;
            7'b0110111: return CLUI;
            7'b0010111: return CAUI;
`ifdef MC_CTRL_HALT_EN
            7'b1110011: return CHALT;
`endif
            default:    return -1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_clear(input logic [2:0] st);
        {e_pcw, e_irw, e_iord, e_mr, e_mw, e_asb, e_rw, e_ill, e_hlt} = '0;
        {e_pcsrc, e_asa, e_aop, e_rsel} = '0;
        e_state = st;
    endtask

    // Compare every control output this cycle, then advance to one step past the next edge.
    task automatic check_cyc(input string tag);
        logic [19:0] o, e;
        #1;
        o = {pc_write, pcsrc, ir_write, iord, mem_read, mem_write, alusrca, alusrcb, aluop,
             resultsel, reg_write, state, illegal, halted};
        e = {e_pcw, e_pcsrc, e_irw, e_iord, e_mr, e_mw, e_asa, e_asb, e_aop,
             e_rsel, e_rw, e_state, e_ill, e_hlt};
        chk(tag, {12'd0, o}, {12'd0, e});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        exp_clear(3'd0);
        exp_count = '0;
        check_cyc("reset_outputs");
        chk("reset_count", inst_count, exp_count);
        rst = 1'b1;
    endtask

    // Drive one instruction through its whole life and check each cycle of its trace.
    task automatic run_inst(input logic [31:0] in, input int fw, input int mw, input logic br,
                            input bit rst_mem, output int kind);
        int k;
        chk("inst_count", inst_count, exp_count);
        inst = in;
        for (int i = 0; i <= fw; i++) begin
            mem_ready = (i == fw);
            br_taken = 1'($urandom_range(0, 1));
            exp_clear(3'd0);
            e_mr = 1'b1;
            e_irw = mem_ready;
            e_pcw = mem_ready;
            check_cyc("fetch");
        end
        mem_ready = 1'($urandom_range(0, 1));
        exp_clear(3'd1);
        check_cyc("decode");
        k = cls_of(in[6:0]);
        mem_ready = 1'($urandom_range(0, 1));
        if (k < 0) begin
            exp_clear(3'd5);
            e_ill = 1'b1;
            check_cyc("trap_entry");
            kind = KTrap;
            return;
        end
        if (k == CHALT) begin
            exp_clear(3'd6);
            e_hlt = 1'b1;
            check_cyc("halt_entry");
            kind = KHalt;
            return;
        end
        br_taken = br;
        exp_clear(3'd2);
        case (k)
            CR:        e_aop = 2'd2;
            CI:        begin e_asb = 1'b1; e_aop = 2'd2; end
            CLD, CST:  e_asb = 1'b1;
            CLUI:      begin e_asa = 2'd2; e_asb = 1'b1; end
            CAUI:      begin e_asa = 2'd1; e_asb = 1'b1; end
            CBR:       begin e_aop = 2'd1; e_pcw = br; e_pcsrc = br ? 2'd1 : 2'd0; end
            CJAL:      begin e_pcw = 1'b1; e_pcsrc = 2'd1; end
            CJALR:     begin e_asb = 1'b1; e_pcw = 1'b1; e_pcsrc = 2'd2; end
            default: ;
        endcase
        check_cyc("exec");
        kind = KRetire;
        if (k == CBR) begin
            exp_count++;
            return;
        end
        if (k == CLD || k == CST) begin
            for (int j = 0; j <= mw; j++) begin
                mem_ready = (j == mw);
                br_taken = 1'($urandom_range(0, 1));
                exp_clear(3'd3);
                e_iord = 1'b1;
                e_mr = (k == CLD);
                e_mw = (k == CST);
                check_cyc("mem");
                if (rst_mem) begin
                    rst = 1'b0;
                    mem_ready = 1'b0;
                    @(posedge clk);
                    #1;
                    exp_clear(3'd0);
                    exp_count = '0;
                    check_cyc("reset_mid_mem");
                    chk("reset_mid_mem_count", inst_count, exp_count);
                    rst = 1'b1;
                    kind = KReset;
                    return;
                end
            end
            if (k == CST) begin
                exp_count++;
                return;
            end
        end
        mem_ready = 1'($urandom_range(0, 1));
        exp_clear(3'd4);
        e_rw = 1'b1;
        e_rsel = (k == CLD) ? 2'd1 : ((k == CJAL || k == CJALR) ? 2'd2 : 2'd0);
        check_cyc("wb");
        exp_count++;
    endtask

    task automatic absorb(input int kind, input int n);
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            br_taken = 1'($urandom_range(0, 1));
            inst = $urandom;
            exp_clear(kind == KHalt ? 3'd6 : 3'd5);
            e_ill = (kind == KTrap);
            e_hlt = (kind == KHalt);
            check_cyc("absorbing");
            chk("absorb_count", inst_count, exp_count);
        end
    endtask

    logic [6:0] ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011,
                             7'b1111111};

    initial begin
        int kind;
        logic [31:0] r;
        rst = 1'b0;
        inst = '0;
        br_taken = 1'b0;
        mem_ready = 1'b0;
        exp_count = '0;
        @(posedge clk);
        #1;
        do_reset();

        // addi, lw with a stalled MEM, beq taken then not taken
        run_inst(32'h0050_0093, 0, 0, 1'b0, 1'b0, kind);
        run_inst(32'h0000_A103, 0, 3, 1'b0, 1'b0, kind);
        run_inst(32'h0000_0463, 0, 0, 1'b1, 1'b0, kind);
        run_inst(32'h0000_0463, 2, 0, 1'b0, 1'b0, kind);
        chk("after_branches", inst_count, 32'd4);

        run_inst(32'hFFFF_FFFF, 1, 0, 1'b0, 1'b0, kind);
        absorb(kind, 10);
        do_reset();

        run_inst(32'h0000_0073, 0, 0, 1'b0, 1'b0, kind);
`ifdef MC_CTRL_HALT_EN
        chk("ecall_kind", kind, KHalt);
`else
        chk("ecall_kind", kind, KTrap);
`endif
        absorb(kind, 4);
        do_reset();

        // counter wrap, then reset asserted while a store waits in MEM
        dut.cnt_q = 32'hFFFF_FFFF;
        exp_count = 32'hFFFF_FFFF;
        run_inst(32'h0050_0093, 0, 0, 1'b0, 1'b0, kind);
        chk("wrap_count", inst_count, 32'd0);
        run_inst(32'h0020_A023, 1, 2, 1'b0, 1'b1, kind);

        for (int n = 0; n < 60; n++) begin
            r = $urandom;
            r[6:0] = ops[$urandom_range(0, 10)];
            run_inst(r, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                     1'b0, kind);
            if (kind == KTrap || kind == KHalt) begin
                absorb(kind, 2);
                do_reset();
            end
        end
        chk("final_count", inst_count, exp_count);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
